instr_dispatcher: RTL and testbench

//   Issuing end of the ImageProcessor instruction interface. Buffers instruction_t

---
 rtl/instr_dispatcher.sv | 124 ++++++++++++
 tb/tb_instr_dispatcher.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatcher.sv
// Issuing end of the ImageProcessor instruction interface: buffers host instructions,
// presents them one at a time on IW and hands each captured result back with valid/ready.
module instr_dispatcher #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned RESULT_LATENCY = 1,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned OP_W           = 4,
   parameter int unsigned PIX_W          = 8,
   parameter int unsigned PIX_N          = 4,
   localparam int unsigned CELL_W        = PIX_W * PIX_N,
   localparam int unsigned INSTR_W       = OP_W + 2 * CELL_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [INSTR_W-1:0] IW,
   input  logic [CELL_W-1:0]  proc_result,
   output logic [CELL_W-1:0]  res_data,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               busy,
   output logic [CNT_W-1:0]   issued_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StHold} state_t;

   logic [INSTR_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]        r_wptr;
   logic [AW:0]        r_rptr;
   state_t             r_state;
   logic [LW-1:0]      r_lat;
   logic [INSTR_W-1:0] r_iw;
   logic [CELL_W-1:0]  r_res_data;
   logic               r_res_valid;
   logic [CNT_W-1:0]   r_issued;

   logic               w_empty;
   logic               w_full;
   logic               w_push;
   logic               w_pop;
   logic [INSTR_W-1:0] w_head;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push  = in_valid && !w_full;
   assign w_pop   = !w_empty && ((r_state == StIdle) || ((r_state == StHold) && res_ready));
   assign w_head  = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= in_instr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_lat       <= '0;
         r_iw        <= '0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
         r_issued    <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (!w_empty) begin
                  r_iw     <= w_head;
                  r_issued <= r_issued + CNT_W'(1);
                  r_lat    <= LW'(RESULT_LATENCY - 1);
                  r_state  <= StWait;
               end
            end
            StWait: begin
               if (r_lat != '0) begin
                  r_lat <= r_lat - 1'b1;
               end else begin
                  r_res_data  <= proc_result;
                  r_res_valid <= 1'b1;
                  r_state     <= StHold;
               end
            end
            StHold: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  // Issue the next instruction in the accept cycle to avoid a bubble.
                  if (!w_empty) begin
                     r_iw     <= w_head;
                     r_issued <= r_issued + CNT_W'(1);
                     r_lat    <= LW'(RESULT_LATENCY - 1);
                     r_state  <= StWait;
                  end else begin
                     r_state <= StIdle;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign in_ready     = !w_full;
   assign IW           = r_iw;
   assign res_data     = r_res_data;
   assign res_valid    = r_res_valid;
   assign issued_count = r_issued;
   assign busy         = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: one default instance (latency 1, 16-bit count) and
// one with latency 3 and a 4-bit count so counter wrap is reachable in a short run.
module tb_instr_dispatcher;

   logic        clk = 1'b0;
   logic        reset_n;

   logic [67:0] in_instr,  in_instr3;
   logic        in_valid,  in_valid3;
   logic        in_ready,  in_ready3;
   logic [67:0] IW,        IW3;
   logic [31:0] proc_result, proc_result3;
   logic [31:0] res_data,  res_data3;
   logic        res_valid, res_valid3;
   logic        res_ready, res_ready3;
   logic        busy,      busy3;
   logic [15:0] issued_count;
   logic [3:0]  issued_count3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Stand-in ImageProcessor: per-pixel ADD / SUB / XOR selected by opcode.
   function automatic logic [31:0] imgp(input logic [67:0] iw);
      logic [31:0] r;
      logic [7:0]  a, b;
      r = '0;
      for (int p = 0; p < 4; p++) begin
         a = iw[32 + 8*p +: 8];
         b = iw[8*p +: 8];
         case (iw[67:64])
            4'd0:    r[8*p +: 8] = a + b;
            4'd1:    r[8*p +: 8] = a - b;
            default: r[8*p +: 8] = a ^ b;
         endcase
      end
      return r;
   endfunction

   assign proc_result  = imgp(IW);
   assign proc_result3 = imgp(IW3);

   instr_dispatcher u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_instr     (in_instr),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .IW           (IW),
      .proc_result  (proc_result),
      .res_data     (res_data),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .busy         (busy),
      .issued_count (issued_count)
   );

   instr_dispatcher #(
      .FIFO_DEPTH     (4),
      .RESULT_LATENCY (3),
      .CNT_W          (4)
   ) u_dut3 (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_instr     (in_instr3),
      .in_valid     (in_valid3),
      .in_ready     (in_ready3),
      .IW           (IW3),
      .proc_result  (proc_result3),
      .res_data     (res_data3),
      .res_valid    (res_valid3),
      .res_ready    (res_ready3),
      .busy         (busy3),
      .issued_count (issued_count3)
   );

   function automatic logic [67:0] mk(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b);
      return {op, {4{a}}, {4{b}}};
   endfunction

   task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp2 [6]  = '{32'h3F3F3F3F, 32'h40404040, 32'h41414141,
                              32'h42424242, 32'h43434343, 32'h44444444};
   logic [31:0] exp3 [8]  = '{32'h30303030, 32'h31313131, 32'h32323232, 32'h33333333,
                              32'h34343434, 32'h35353535, 32'h36363636, 32'h37373737};
   logic [7:0]  exp6 [17] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2,
                              8'hAD, 8'hAC, 8'hAF, 8'hAE, 8'hA9, 8'hA8, 8'hAB, 8'hAA, 8'hB5};

   initial begin
      int          acc, n, pi, wrapped;
      logic [31:0] got [8];
      int          at  [8];
      logic [67:0] t4_iw;
      logic [3:0]  prev;

      reset_n   = 1'b0;
      in_instr  = '0;  in_valid  = 1'b0;  res_ready  = 1'b0;
      in_instr3 = '0;  in_valid3 = 1'b0;  res_ready3 = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // Reset state
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_iw", IW, 0);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_res_data", res_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_count", issued_count, 0);

      // Test 1: single ADD, latency 1
      in_valid = 1'b1;
      in_instr = mk(4'd0, 8'h10, 8'h05);
      tick();
      in_valid = 1'b0;
      check_eq("t1_iw_early", IW, 0);
      tick();
      check_eq("t1_iw", IW, mk(4'd0, 8'h10, 8'h05));
      check_eq("t1_rv_early", res_valid, 0);
      check_eq("t1_count", issued_count, 1);
      tick();
      check_eq("t1_rv", res_valid, 1);
      check_eq("t1_data", res_data, 32'h15151515);
      tick();
      check_eq("t1_hold_rv", res_valid, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_eq("t1_rv_clear", res_valid, 0);
      check_eq("t1_busy", busy, 0);

      // Test 2: six pushes with the host stalled
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_instr = mk(4'd1, 8'h40 + 8'(i), 8'h01);
         if (in_ready) acc++;
         tick();
      end
      check_eq("t2_accepted", acc, 5);
      check_eq("t2_in_ready", in_ready, 0);
      tick(); tick();
      check_eq("t2_iw_frozen", IW, mk(4'd1, 8'h40, 8'h01));
      check_eq("t2_rv_held", res_valid, 1);
      res_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
         if (res_valid) begin
            got[n] = res_data;
            n++;
         end
         if (in_valid && in_ready) begin
            tick();
            in_valid = 1'b0;
         end else begin
            tick();
         end
      end
      check_eq("t2_count", n, 6);
      for (int k = 0; k < n; k++) check_eq("t2_order", got[k], exp2[k]);

      // Test 3: eight ADDs, host always ready
      tick(); tick();
      n  = 0;
      pi = 0;
      in_valid = 1'b1;
      in_instr = mk(4'd0, 8'h10, 8'h20);
      for (int cyc = 0; cyc < 80 && n < 8; cyc++) begin
         if (res_valid) begin
            got[n] = res_data;
            at[n]  = cyc;
            n++;
         end
         if (in_valid && in_ready) pi++;
         tick();
         in_valid = (pi < 8);
         in_instr = mk(4'd0, 8'h10 + 8'(pi), 8'h20);
      end
      in_valid = 1'b0;
      check_eq("t3_count", n, 8);
      for (int k = 0; k < n; k++) check_eq("t3_order", got[k], exp3[k]);
      for (int k = 1; k < n; k++) check_eq("t3_gap", at[k] - at[k-1], 2);

      // Test 4: latency 3 on the second instance
      t4_iw = mk(4'd0, 8'h07, 8'h09);
      in_valid3 = 1'b1;
      in_instr3 = t4_iw;
      tick();
      in_valid3 = 1'b0;
      tick();
      check_eq("t4_iw", IW3, t4_iw);
      check_eq("t4_count", issued_count3, 1);
      for (int k = 0; k < 2; k++) begin
         tick();
         check_eq("t4_rv_early", res_valid3, 0);
         check_eq("t4_iw_stable", IW3, t4_iw);
      end
      tick();
      check_eq("t4_rv", res_valid3, 1);
      check_eq("t4_data", res_data3, 32'h10101010);
      check_eq("t4_iw_at_cap", IW3, t4_iw);
      res_ready3 = 1'b1;
      tick();
      res_ready3 = 1'b0;
      check_eq("t4_rv_clear", res_valid3, 0);

      // Test 5: asynchronous reset while in WAIT with three entries queued
      for (int i = 0; i < 4; i++) begin
         in_valid3 = 1'b1;
         in_instr3 = mk(4'd2, 8'h50 + 8'(i), 8'h00);
         tick();
      end
      in_valid3 = 1'b0;
      check_eq("t5_busy_pre", busy3, 1);
      check_eq("t5_rv_pre", res_valid3, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("t5_iw_async", IW3, 0);
      check_eq("t5_busy_async", busy3, 0);
      check_eq("t5_in_ready_async", in_ready3, 1);
      check_eq("t5_count_async", issued_count3, 0);
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick(); tick(); tick();
      check_eq("t5_busy_post", busy3, 0);
      check_eq("t5_rv_post", res_valid3, 0);
      check_eq("t5_iw_post", IW3, 0);

      // Test 6: 4-bit issue counter wraps; 17 pushes wrap the FIFO pointers several times
      res_ready3 = 1'b1;
      n       = 0;
      pi      = 0;
      wrapped = 0;
      prev    = issued_count3;
      in_valid3 = 1'b1;
      in_instr3 = mk(4'd2, 8'h00, 8'hA5);
      for (int cyc = 0; cyc < 300 && n < 17; cyc++) begin
         if (res_valid3) begin
            check_eq("t6_res", res_data3, {4{exp6[n]}});
            n++;
         end
         if (in_valid3 && in_ready3) pi++;
         tick();
         if (issued_count3 != prev) begin
            check_eq("t6_cnt_step", issued_count3, 4'(prev + 4'd1));
            if (prev == 4'hF) wrapped = 1;
            prev = issued_count3;
         end
         in_valid3 = (pi < 17);
         in_instr3 = mk(4'd2, 8'(pi), 8'hA5);
      end
      in_valid3 = 1'b0;
      tick();
      check_eq("t6_count", n, 17);
      check_eq("t6_wrapped", wrapped, 1);
      check_eq("t6_final_cnt", issued_count3, 1);
      check_eq("t6_busy_end", busy3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
